// File: rtl/processor_debug_pkg.sv
// Shared debug types: dump FSM states, default widths and the dump word payload.
package processor_debug_pkg;

  localparam int unsigned DUMP_IDX_WIDTH  = 5;
  localparam int unsigned DUMP_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  typedef struct packed {
    logic [DUMP_IDX_WIDTH-1:0]  index;
    logic [DUMP_DATA_WIDTH-1:0] data;
    logic                       last;
  } dump_word_t;

endpackage

// File: rtl/regfile_dump.sv
// Register file dump engine: walks r0..r(NUM_REGS-1) through a dedicated read
// port and streams each value with its index over a valid/ready channel.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN (running XOR of accepted words).
module regfile_dump
  import processor_debug_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = DUMP_DATA_WIDTH,
  parameter int unsigned IDX_WIDTH  = DUMP_IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic [IDX_WIDTH-1:0]  ctrl_readReg,
  input  logic [DATA_WIDTH-1:0] data_readReg,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_WIDTH-1:0]  dump_index,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dump_checksum
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  index_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic                  accept;

  assign accept = (state_q == ST_SEND) && dump_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one read cycle then a send cycle per register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: state_d = ST_SEND;
      ST_SEND: if (dump_ready) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register; read select is idle-zero.
  always_comb begin
    busy         = 1'b0;
    dump_valid   = 1'b0;
    done         = 1'b0;
    ctrl_readReg = '0;
    case (state_q)
      ST_READ: begin
        busy         = 1'b1;
        ctrl_readReg = idx_q;
      end
      ST_SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Index counter and captured word; the word register holds through a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) idx_q <= '0;
      else if (accept && (idx_q != LAST_IDX)) idx_q <= idx_q + IDX_WIDTH'(1);

      if (state_q == ST_READ) begin
        index_q <= idx_q;
        data_q  <= data_readReg;
        last_q  <= (idx_q == LAST_IDX);
      end else if (accept) begin
        last_q  <= 1'b0;
      end
    end
  end

  assign dump_index = index_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Running XOR of accepted words, cleared when a dump is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            csum_q <= '0;
    else if ((state_q == ST_IDLE) && start) csum_q <= '0;
    else if (accept)                       csum_q <= csum_q ^ data_q;
  end

  assign dump_checksum = csum_q;
`else
  assign dump_checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Directed + randomized bench for regfile_dump with a behavioural register
// file and a stream-level reference model.
module tb_regfile_dump;
  import processor_debug_pkg::*;

  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          dump_ready = 1'b0;
  logic          busy, dump_valid, dump_last, dump_done;
  logic [IW-1:0] ctrl_readReg, dump_index;
  logic [DW-1:0] data_readReg, dump_data, dump_checksum;

  logic [DW-1:0] rf [NREG];
  dump_word_t    got [NREG];

  int checks   = 0;
  int failures = 0;

  int nw, nd, dcyc, fv;

  regfile_dump #(.NUM_REGS(NREG), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .ctrl_readReg (ctrl_readReg),
    .data_readReg (data_readReg),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_index   (dump_index),
    .dump_data    (dump_data),
    .dump_last    (dump_last),
    .done         (dump_done),
    .dump_checksum(dump_checksum)
  );

  always #5 clock = ~clock;

  assign data_readReg = rf[ctrl_readReg];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_csum(input logic [DW-1:0] x);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    return x;
`else
    return (x & '0);
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_valid"}, 64'(dump_valid), 64'(0));
    chk({tag, "_last"},  64'(dump_last), 64'(0));
    chk({tag, "_done"},  64'(dump_done), 64'(0));
    chk({tag, "_index"}, 64'(dump_index), 64'(0));
    chk({tag, "_data"},  64'(dump_data), 64'(0));
    chk({tag, "_rdsel"}, 64'(ctrl_readReg), 64'(0));
    chk({tag, "_csum"},  64'(dump_checksum), 64'(0));
  endtask

  // One dump from a start pulse; entered and left #1 after a rising edge.
  task automatic run_dump(input int ready_pct, input int stall_idx, input int wr_word,
                          input int rst_word, input bit extra_start,
                          output int nwords, output int ndone, output int done_cyc,
                          output int first_vld);
    int cyc;
    int stall_cnt;
    bit fin;
    bit wr_done;
    logic [DW-1:0] xsum;
    nwords = 0; ndone = 0; done_cyc = -1; first_vld = -1;
    stall_cnt = 0; fin = 1'b0; wr_done = 1'b0; xsum = '0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_in_read", 64'(busy), 64'(1));
    chk("valid_in_read", 64'(dump_valid), 64'(0));
    while (!fin) begin
      start = extra_start && (cyc == 9 || cyc == 10 || cyc == 40);
      if (cyc > 400) begin
        chk("timeout_waiting_done", 64'(ndone), 64'(1));
        fin = 1'b1;
      end else if (dump_done) begin
        ndone++;
        done_cyc = cyc;
        chk("last_low_at_done", 64'(dump_last), 64'(0));
        chk("checksum_at_done", 64'(dump_checksum), 64'(exp_csum(xsum)));
        start = 1'b0;
        @(posedge clock); #1;
        chk("done_one_cycle", 64'(dump_done), 64'(0));
        chk("busy_low_idle", 64'(busy), 64'(0));
        chk("checksum_held", 64'(dump_checksum), 64'(exp_csum(xsum)));
        fin = 1'b1;
      end else begin
        if (dump_valid) begin
          if (first_vld < 0) first_vld = cyc;
          chk("word_index", 64'(dump_index), 64'(nwords));
          chk("word_data", 64'(dump_data), 64'(rf[nwords[4:0]]));
          chk("word_last", 64'(dump_last), 64'(nwords == NREG - 1));
          if (nwords < NREG) got[nwords] = '{index: dump_index, data: dump_data, last: dump_last};
          if (rst_word >= 0 && nwords == rst_word) begin
            #2 reset = 1'b0;
            #1;
            chk_all_zero("async_reset");
            repeat (3) begin
              @(posedge clock); #1;
              chk("no_done_in_reset", 64'(dump_done), 64'(0));
            end
            reset = 1'b1;
            fin = 1'b1;
          end else begin
            if (wr_word >= 0 && nwords == wr_word && !wr_done) begin
              rf[20] = 32'hDEAD_BEEF;
              wr_done = 1'b1;
            end
            if (stall_idx >= 0 && nwords == stall_idx && stall_cnt < 5) begin
              dump_ready = 1'b0;
              stall_cnt++;
            end else begin
              dump_ready = ($urandom_range(99) < 32'(ready_pct));
            end
            if (dump_ready) begin
              xsum ^= dump_data;
              nwords++;
            end
          end
        end else begin
          dump_ready = 1'($urandom_range(1));
        end
        if (!fin) begin
          @(posedge clock); #1;
          cyc++;
        end
      end
    end
    dump_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", 64'(busy), 64'(0));

    // Full dump with ready held high
    for (int i = 0; i < int'(NREG); i++) rf[i] = 32'hA000_0000 + 32'(i);
    run_dump(100, -1, -1, -1, 1'b0, nw, nd, dcyc, fv);
    chk("t1_words", 64'(nw), 64'(32));
    chk("t1_done_pulses", 64'(nd), 64'(1));
    chk("t1_done_latency", 64'(dcyc), 64'(65));
    chk("t1_first_valid", 64'(fv), 64'(2));
    for (int i = 0; i < int'(NREG); i++) begin
      chk("t1_data", 64'(got[i].data), 64'(32'hA000_0000 + 32'(i)));
      chk("t1_index", 64'(got[i].index), 64'(i));
    end
    chk("t1_last_final", 64'(got[31].last), 64'(1));
    chk("t1_last_penult", 64'(got[30].last), 64'(0));

    // Backpressure while r3 is presented
    run_dump(100, 3, -1, -1, 1'b0, nw, nd, dcyc, fv);
    chk("t2_words", 64'(nw), 64'(32));
    chk("t2_done_latency", 64'(dcyc), 64'(70));
    chk("t2_after_stall", 64'(got[4].index), 64'(4));

    // start while busy is ignored
    run_dump(100, -1, -1, -1, 1'b1, nw, nd, dcyc, fv);
    chk("t3_words", 64'(nw), 64'(32));
    chk("t3_done_pulses", 64'(nd), 64'(1));
    repeat (4) begin
      @(posedge clock); #1;
      chk("t3_no_queued_start", 64'(busy), 64'(0));
    end

    // Reset during word 10, then a clean restart
    run_dump(100, -1, -1, 10, 1'b0, nw, nd, dcyc, fv);
    chk("t4_words_before_reset", 64'(nw), 64'(10));
    chk("t4_no_done", 64'(nd), 64'(0));
    run_dump(100, -1, -1, -1, 1'b0, nw, nd, dcyc, fv);
    chk("t4_restart_words", 64'(nw), 64'(32));
    chk("t4_restart_first_idx", 64'(got[0].index), 64'(0));
    chk("t4_restart_latency", 64'(dcyc), 64'(65));

    // Write to r20 during word 5 is reflected
    for (int i = 0; i < int'(NREG); i++) rf[i] = 32'hA000_0000 + 32'(i);
    run_dump(100, -1, 5, -1, 1'b0, nw, nd, dcyc, fv);
    chk("t5_r20_snapshot", 64'(got[20].data), 64'(32'hDEAD_BEEF));
    chk("t5_r19", 64'(got[19].data), 64'(32'hA000_0013));

    // r_i = i: XOR of 0..31 is zero
    for (int i = 0; i < int'(NREG); i++) rf[i] = 32'(i);
    run_dump(100, -1, -1, -1, 1'b0, nw, nd, dcyc, fv);
    chk("t6_checksum_zero", 64'(dump_checksum), 64'(0));

    // Random register contents and random backpressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] = $urandom;
      run_dump(40 + 20 * k, -1, -1, -1, 1'b0, nw, nd, dcyc, fv);
      chk("rand_words", 64'(nw), 64'(32));
      chk("rand_done", 64'(nd), 64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
